// File: rtl/mix_columns_iter.sv
// mix_columns_iter
//   Iterative AES (Inv)MixColumns engine for a full 128-bit state.
//   A state is latched on accept and transformed in place,
//   COLS_PER_CYCLE columns per clock. The result is presented with a
//   valid/ready handshake.
//   Byte layout: column c = bits [32c+31:32c], row r = bits [8r+7:8r].
//   Build option: define MIXCOL_FWD_EN to build the forward (MixColumns)
//   path. Without it the block is InvMixColumns-only and ignores inv.
module mix_columns_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         inv,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    // Counter step and the start column of the final group. For 4 columns per
    // cycle the step truncates to 0, which is harmless because the only group
    // starts at column 0.
    localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] CNT_LAST = 2'(4 - COLS_PER_CYCLE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_nxt_s;
    logic           in_ready_r;
    logic           out_valid_r;
    logic [127:0]   work_r;
    logic [127:0]   work_nxt_s;
    logic [1:0]     cnt_r;
    logic           mode_r;
    logic           accept_s;
    logic [1:0]     idx_s;
    logic [31:0]    col_s;

    // GF(2^8) multiply by x, reduced modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // InvMixColumns of one column: b_r = e*a_r ^ b*a_(r+1) ^ d*a_(r+2) ^ 9*a_(r+3).
    function automatic logic [31:0] mix_inv(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        logic [31:0] res;
        res = 32'h0000_0000;
        for (int r = 0; r < 4; r++) begin
            a[r]  = col[8*r +: 8];
            x2    = xtime(a[r]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[r] = x8 ^ a[r];
            mb[r] = x8 ^ x2 ^ a[r];
            md[r] = x8 ^ x4 ^ a[r];
            me[r] = x8 ^ x4 ^ x2;
        end
        for (int r = 0; r < 4; r++) begin
            res[8*r +: 8] = me[r] ^ mb[(r + 1) % 4] ^ md[(r + 2) % 4] ^ m9[(r + 3) % 4];
        end
        return res;
    endfunction

`ifdef MIXCOL_FWD_EN
    // MixColumns of one column: b_r = 2*a_r ^ 3*a_(r+1) ^ a_(r+2) ^ a_(r+3).
    function automatic logic [31:0] mix_fwd(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m2 [4];
        logic [31:0] res;
        res = 32'h0000_0000;
        for (int r = 0; r < 4; r++) begin
            a[r]  = col[8*r +: 8];
            m2[r] = xtime(a[r]);
        end
        for (int r = 0; r < 4; r++) begin
            res[8*r +: 8] = m2[r] ^ m2[(r + 1) % 4] ^ a[(r + 1) % 4]
                          ^ a[(r + 2) % 4] ^ a[(r + 3) % 4];
        end
        return res;
    endfunction
`else
    // Direction is fixed to inverse in this build; the mode input and the
    // latched mode are deliberately left without a consumer.
    logic unused_mode_s;
    assign unused_mode_s = inv ^ mode_r;
`endif

    assign accept_s = in_valid && in_ready_r;

    // Next-state logic for the IDLE/BUSY/DONE sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Transform the current column group of the working state in place.
    always_comb begin
        work_nxt_s = work_r;
        idx_s      = 2'd0;
        col_s      = 32'h0000_0000;
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            idx_s = cnt_r + 2'(j);
            col_s = work_r[{idx_s, 5'd0} +: 32];
`ifdef MIXCOL_FWD_EN
            if (mode_r) begin
                col_s = mix_inv(col_s);
            end else begin
                col_s = mix_fwd(col_s);
            end
`else
            col_s = mix_inv(col_s);
`endif
            work_nxt_s[{idx_s, 5'd0} +: 32] = col_s;
        end
    end

    // Sequencer state and the registered handshake flags derived from it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == IDLE);
            out_valid_r <= (state_nxt_s == DONE);
        end
    end

    // Working state, column counter and direction latched at accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work_r <= 128'h0;
            cnt_r  <= 2'd0;
            mode_r <= 1'b0;
        end else if (accept_s) begin
            work_r <= state_in;
            cnt_r  <= 2'd0;
`ifdef MIXCOL_FWD_EN
            mode_r <= inv;
`else
            mode_r <= 1'b1;
`endif
        end else if (state_r == BUSY) begin
            work_r <= work_nxt_s;
            if (cnt_r == CNT_LAST) begin
                cnt_r <= 2'd0;
            end else begin
                cnt_r <= cnt_r + CNT_STEP;
            end
        end else begin
            work_r <= work_r;
            cnt_r  <= cnt_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign state_out = work_r;

endmodule
